// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: req/ack word fetches into a small {PC, instr} FIFO, valid/ready to decode.
// Optional performance counters (oFetchCnt, oStallCnt) are built when IFU_PERF_CNT_EN is defined.
module instr_fetch_unit #(
  parameter logic [31:0] TEXT_BASE = 32'h0040_0000,
  parameter int          DEPTH     = 2
) (
  input  logic        iCLK,
  input  logic        iRST,
  output logic        oIMemReq,
  output logic [31:0] oIMemAddr,
  input  logic        iIMemAck,
  input  logic [31:0] iIMemData,
  output logic        oValid,
  input  logic        iReady,
  output logic [31:0] oInstr,
  output logic [6:0]  oOp,
  output logic [31:0] oPC,
  input  logic        iRedirect,
  input  logic [31:0] iRedirectPC
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] oFetchCnt,
  output logic [31:0] oStallCnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  // Memory side: req high and no ack is a held request. Decode side: data moves on valid & ready.
  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DROP} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   addr_q, addr_d;
  logic          req_q, req_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   mem_pc_q    [DEPTH];
  logic [31:0]   mem_instr_q [DEPTH];
  logic          ack, push, pop, valid;

  always_comb begin
    ack      = req_q & iIMemAck;
    valid    = (count_q != '0);
    push     = 1'b0;
    pop      = valid & iReady & ~iRedirect;
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    req_d    = req_q & ~ack;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    case (state_q)
      S_WAIT: begin
        if (ack) begin
          push    = ~iRedirect;
          state_d = S_FETCH;
        end else if (iRedirect) begin
          state_d = S_DROP;
        end
      end
      S_DROP: if (ack) state_d = S_FETCH;
      default: ;
    endcase

    if (iRedirect) begin
      pc_d     = iRedirectPC & 32'hFFFF_FFFC;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) pc_d = pc_q + 32'd4;
      count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
    end

    // Issue only with no request left outstanding and room for its data.
    if (!iRedirect && state_q != S_DROP && state_d == S_FETCH && count_d < DEPTH_C) begin
      state_d = S_WAIT;
      req_d   = 1'b1;
      addr_d  = pc_d;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q  <= S_FETCH;
      pc_q     <= TEXT_BASE;
      addr_q   <= TEXT_BASE;
      req_q    <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      req_q    <= req_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: head outputs are masked while the FIFO is empty.
  always_ff @(posedge iCLK) begin
    if (push) begin
      mem_pc_q[wr_ptr_q]    <= addr_q;
      mem_instr_q[wr_ptr_q] <= iIMemData;
    end
  end

  assign oIMemReq  = req_q;
  assign oIMemAddr = addr_q;
  assign oValid    = valid;
  assign oInstr    = valid ? mem_instr_q[rd_ptr_q] : 32'h0;
  assign oPC       = valid ? mem_pc_q[rd_ptr_q] : 32'h0;
  assign oOp       = oInstr[6:0];

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d, stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + 32'(push);
    stall_cnt_d = stall_cnt_q + 32'(req_q & ~iIMemAck);
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign oFetchCnt = fetch_cnt_q;
  assign oStallCnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random traffic against a queue-based model.
module tb_instr_fetch_unit;

  localparam logic [31:0] TEXT_BASE = 32'h0040_0000;
  localparam int          DEPTH     = 2;

  logic        iCLK, iRST;
  logic        oIMemReq, iIMemAck, oValid, iReady, iRedirect;
  logic [31:0] oIMemAddr, iIMemData, oInstr, oPC, iRedirectPC;
  logic [6:0]  oOp;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] oFetchCnt, oStallCnt;
`endif

  instr_fetch_unit #(.TEXT_BASE(TEXT_BASE), .DEPTH(DEPTH)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .oIMemReq(oIMemReq), .oIMemAddr(oIMemAddr), .iIMemAck(iIMemAck), .iIMemData(iIMemData),
    .oValid(oValid), .iReady(iReady), .oInstr(oInstr), .oOp(oOp), .oPC(oPC),
    .iRedirect(iRedirect), .iRedirectPC(iRedirectPC)
`ifdef IFU_PERF_CNT_EN
    , .oFetchCnt(oFetchCnt), .oStallCnt(oStallCnt)
`endif
  );

  // Clock / reset
  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int n_checks = 0, n_errors = 0;

  // Model state: expected FIFO contents {pc, instr}, next fetch PC, drop flag, counters.
  logic [63:0] exp_q[$];
  logic [31:0] m_pc, m_hold_addr;
  bit          m_drop, m_hold;
  int          m_pushes, m_stalls, cyc;
  int          push_cyc[$];

  // Stimulus knobs
  int  ready_mode, min_wait, max_wait, redir_pct, cur_wait, req_age;
  bit  f_redir, f_noack;
  logic [31:0] f_rpc;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_3C3C;
  endfunction

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk(act === exp, name, act, exp);
  endtask

  task automatic model_reset();
    exp_q.delete();
    push_cyc.delete();
    m_pc     = TEXT_BASE;
    m_drop   = 0;
    m_hold   = 0;
    m_pushes = 0;
    m_stalls = 0;
    req_age  = 0;
    cur_wait = min_wait;
  endtask

  task automatic check_outputs();
    logic [63:0] h;
    chk_eq("valid", {31'd0, oValid}, {31'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      h = exp_q[0];
      chk_eq("head_pc", oPC, h[63:32]);
      chk_eq("head_instr", oInstr, h[31:0]);
      chk_eq("head_op", {25'd0, oOp}, {25'd0, h[6:0]});
    end
    if (m_hold) begin
      chk_eq("req_held", {31'd0, oIMemReq}, 32'd1);
      chk_eq("addr_stable", oIMemAddr, m_hold_addr);
    end
    if (oIMemReq && !m_drop) begin
      chk_eq("fetch_addr", oIMemAddr, m_pc);
      chk(exp_q.size() < DEPTH, "capacity", exp_q.size(), DEPTH - 1);
    end
  endtask

  // Driver: one cycle of stimulus, with the model advanced for the coming edge.
  task automatic step();
    bit          redir, rdy, ack, acked, pop;
    logic [31:0] rpc;
    check_outputs();
    case (ready_mode)
      0: rdy = 0;
      1: rdy = 1;
      default: rdy = 1'($urandom_range(0, 1));
    endcase
    redir = f_redir || (redir_pct > 0 && $urandom_range(0, 99) < redir_pct);
    if (f_redir) rpc = f_rpc;
    else if ($urandom_range(0, 9) == 0) rpc = 32'hFFFF_FFF0 + $urandom_range(0, 15);
    else rpc = TEXT_BASE + $urandom_range(0, 511);
    ack = oIMemReq && !f_noack && (req_age >= cur_wait);
    iReady      = rdy;
    iRedirect   = redir;
    iRedirectPC = rpc;
    iIMemAck    = ack;
    iIMemData   = ack ? mem_fn(oIMemAddr) : $urandom();
    f_redir = 0;
    f_noack = 0;

    acked = oIMemReq && ack;
    if (oIMemReq && !ack) m_stalls++;
    if (acked) begin
      req_age  = 0;
      cur_wait = $urandom_range(min_wait, max_wait);
    end else if (oIMemReq) req_age++;
    m_hold      = oIMemReq && !ack;
    m_hold_addr = oIMemAddr;
    pop = (exp_q.size() != 0) && rdy && !redir;
    if (redir) begin
      exp_q.delete();
      m_pc   = rpc & 32'hFFFF_FFFC;
      m_drop = oIMemReq && !ack;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (acked) begin
        if (m_drop) m_drop = 0;
        else begin
          exp_q.push_back({m_pc, mem_fn(m_pc)});
          m_pc = m_pc + 32'd4;
          m_pushes++;
          push_cyc.push_back(cyc);
        end
      end
    end
    cyc++;
    @(posedge iCLK);
    @(negedge iCLK);
  endtask

  task automatic do_reset();
    iRST      = 1'b1;
    iIMemAck  = 1'b0;
    iIMemData = '0;
    iReady    = 1'b0;
    iRedirect = 1'b0;
    iRedirectPC = '0;
    model_reset();
    repeat (2) @(negedge iCLK);
    chk_eq("rst_req", {31'd0, oIMemReq}, 32'd0);
    chk_eq("rst_addr", oIMemAddr, TEXT_BASE);
    chk_eq("rst_valid", {31'd0, oValid}, 32'd0);
    chk_eq("rst_instr", oInstr, 32'd0);
    chk_eq("rst_pc", oPC, 32'd0);
`ifdef IFU_PERF_CNT_EN
    chk_eq("rst_fetch_cnt", oFetchCnt, 32'd0);
    chk_eq("rst_stall_cnt", oStallCnt, 32'd0);
`endif
    iRST = 1'b0;
  endtask

  task automatic run_until_req(input string name);
    int g = 0;
    while (!oIMemReq && g < 20) begin step(); g++; end
    chk(oIMemReq, name, {31'd0, oIMemReq}, 32'd1);
  endtask

  task automatic run_until_valid(input string name);
    int g = 0;
    while (!oValid && g < 50) begin step(); g++; end
    chk(oValid, name, {31'd0, oValid}, 32'd1);
  endtask

  initial begin
    iRST = 1'b1;
    f_redir = 0; f_noack = 0; f_rpc = '0; cyc = 0;
    ready_mode = 1; min_wait = 0; max_wait = 0; redir_pct = 0;

    // Zero-wait streaming from reset
    do_reset();
    step();
    chk_eq("t1_first_req", {31'd0, oIMemReq}, 32'd1);
    chk_eq("t1_not_valid_yet", {31'd0, oValid}, 32'd0);
    step();
    chk_eq("t1_valid", {31'd0, oValid}, 32'd1);
    chk_eq("t1_pc0", oPC, 32'h0040_0000);
    step();
    chk_eq("t1_pc1", oPC, 32'h0040_0004);
    step();
    chk_eq("t1_pc2", oPC, 32'h0040_0008);
    chk_eq("t1_op", {25'd0, oOp}, {25'd0, mem_fn(32'h0040_0008) & 32'h7F});

    // Back-pressure fills the FIFO, then drains
    ready_mode = 0;
    do_reset();
    repeat (6) step();
    chk_eq("t2_pushes", m_pushes, 2);
    chk_eq("t2_req_low", {31'd0, oIMemReq}, 32'd0);
    chk_eq("t2_pc_held", oPC, 32'h0040_0000);
    ready_mode = 1;
    run_until_req("t2_resume_req");
    chk_eq("t2_resume_addr", oIMemAddr, 32'h0040_0008);
    repeat (4) step();

    // Ack on third request cycle
    min_wait = 2; max_wait = 2;
    do_reset();
    begin
      int g = 0;
      while (m_pushes < 10 && g < 100) begin step(); g++; end
      chk(m_pushes == 10, "t3_ten_fetches", m_pushes, 10);
    end
    chk_eq("t3_model_stalls", m_stalls, 20);
    for (int i = 1; i < push_cyc.size(); i++)
      chk_eq("t3_push_spacing", push_cyc[i] - push_cyc[i-1], 3);
`ifdef IFU_PERF_CNT_EN
    chk_eq("t3_fetch_cnt", oFetchCnt, 32'd10);
    chk_eq("t3_stall_cnt", oStallCnt, 32'd20);
`endif

    // Redirect while a request is outstanding
    begin
      int g = 0;
      while (!(oIMemReq && req_age == 1) && g < 20) begin step(); g++; end
      chk(oIMemReq && req_age == 1, "t4_in_wait", {31'd0, oIMemReq}, 32'd1);
    end
    f_redir = 1; f_noack = 1; f_rpc = 32'h0040_0100;
    step();
    chk_eq("t4_flushed", {31'd0, oValid}, 32'd0);
    run_until_valid("t4_valid");
    chk_eq("t4_pc", oPC, 32'h0040_0100);

    // Redirect coinciding with ack and pop, unaligned target
    min_wait = 0; max_wait = 0; cur_wait = 0;
    begin
      int g = 0;
      while (!(oValid && oIMemReq) && g < 20) begin step(); g++; end
      chk(oValid && oIMemReq, "t5_streaming", {31'd0, oValid}, 32'd1);
    end
    f_redir = 1; f_rpc = 32'h0040_0102;
    step();
    chk_eq("t5_empty", {31'd0, oValid}, 32'd0);
    run_until_req("t5_req");
    chk_eq("t5_addr", oIMemAddr, 32'h0040_0100);

    // PC wrap, then reset mid-wait
    f_redir = 1; f_rpc = 32'hFFFF_FFFC;
    step();
    run_until_valid("t6_valid");
    chk_eq("t6_pc_top", oPC, 32'hFFFF_FFFC);
    step();
    chk_eq("t6_pc_wrap", oPC, 32'h0000_0000);
    min_wait = 5; max_wait = 5; cur_wait = 5;
    begin
      int g = 0;
      while (!(oIMemReq && req_age >= 1) && g < 20) begin step(); g++; end
    end
    iRST = 1'b1;
    #1;
    chk_eq("t6_rst_req", {31'd0, oIMemReq}, 32'd0);
    chk_eq("t6_rst_valid", {31'd0, oValid}, 32'd0);
    @(negedge iCLK);
    do_reset();

    // Random traffic
    min_wait = 0; max_wait = 3; cur_wait = 0;
    ready_mode = 2; redir_pct = 4;
    repeat (3000) step();
`ifdef IFU_PERF_CNT_EN
    chk_eq("rand_fetch_cnt", oFetchCnt, m_pushes);
    chk_eq("rand_stall_cnt", oStallCnt, m_stalls);
`endif
    chk(m_pushes > 100, "rand_progress", m_pushes, 101);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
